// File: rtl/wallace_mac_acc.sv
// Frame accumulator behind the 4x4 multiplier stage.
// Sums unsigned products with saturation and presents each completed frame.
module wallace_mac_acc #(
  parameter int ACC_W     = 16,
  parameter int MAX_TERMS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [7:0]       prod,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       term_cnt,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_TERMS);

  state_t           state;
  logic [ACC_W:0]   sum;
  logic [7:0]       cnt_next;
  logic             in_hs;
  logic             out_hs;

  // One spare bit on the sum exposes any overflow past the accumulator width.
  assign sum      = {1'b0, acc_out} + {{(ACC_W - 7){1'b0}}, prod};
  assign cnt_next = term_cnt + 8'd1;
  assign in_hs    = in_valid && (state == ACC);
  assign out_hs   = out_ready && (state == HOLD);

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      acc_out  <= '0;
      term_cnt <= '0;
      ovf      <= 1'b0;
    end else if (clr || out_hs) begin
      state    <= ACC;
      acc_out  <= '0;
      term_cnt <= '0;
      ovf      <= 1'b0;
    end else if (in_hs) begin
      term_cnt <= cnt_next;
      if (sum[ACC_W]) begin
        acc_out <= '1;
        ovf     <= 1'b1;
      end else begin
        acc_out <= sum[ACC_W-1:0];
      end
      if (in_last || (cnt_next == MAX_CNT)) begin
        state <= HOLD;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mac_acc.sv
// Directed bench for wallace_mac_acc: a default 16-bit instance plus a
// 10-bit instance sharing the same stimulus for the saturation case.
module tb_wallace_mac_acc;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic [7:0] prod;
  logic       in_valid;
  logic       in_last;
  logic       out_ready;

  logic        in_ready, ovf, out_valid;
  logic [15:0] acc_out;
  logic [7:0]  term_cnt;

  logic        in_ready10, ovf10, out_valid10;
  logic [9:0]  acc_out10;
  logic [7:0]  term_cnt10;

  int checks   = 0;
  int failures = 0;

  wallace_mac_acc #(.ACC_W(16), .MAX_TERMS(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .prod(prod),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .acc_out(acc_out), .term_cnt(term_cnt), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  wallace_mac_acc #(.ACC_W(10), .MAX_TERMS(16)) dut10 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .prod(prod),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready10),
    .acc_out(acc_out10), .term_cnt(term_cnt10), .ovf(ovf10),
    .out_valid(out_valid10), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of input, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] p, input logic l);
    in_valid = v;
    prod     = p;
    in_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; prod = 8'd0;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #2;
    checkOutput("rst_acc", 32'(acc_out), 0);
    checkOutput("rst_cnt", 32'(term_cnt), 0);
    checkOutput("rst_ovf", 32'(ovf), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 1);
    #10 rst_n = 1'b1;

    // Basic frame 15+225+100+1
    applyStimulus(1, 8'd15, 0);
    checkOutput("basic_first_acc", 32'(acc_out), 15);
    applyStimulus(1, 8'd225, 0);
    applyStimulus(1, 8'd100, 0);
    checkOutput("basic_mid_valid", 32'(out_valid), 0);
    applyStimulus(1, 8'd1, 1);
    checkOutput("basic_out_valid", 32'(out_valid), 1);
    checkOutput("basic_acc", 32'(acc_out), 341);
    checkOutput("basic_cnt", 32'(term_cnt), 4);
    checkOutput("basic_ovf", 32'(ovf), 0);
    checkOutput("basic_in_ready", 32'(in_ready), 0);
    applyStimulus(0, 8'd0, 0);
    checkOutput("basic_consumed_ready", 32'(in_ready), 1);
    checkOutput("basic_consumed_valid", 32'(out_valid), 0);
    checkOutput("basic_consumed_acc", 32'(acc_out), 0);

    // Backpressure: frame of 50, then a held term of 9 while stalled
    out_ready = 1'b0;
    applyStimulus(1, 8'd20, 0);
    applyStimulus(1, 8'd30, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 8'd9, 0);
      checkOutput("bp_out_valid", 32'(out_valid), 1);
      checkOutput("bp_acc", 32'(acc_out), 50);
      checkOutput("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    applyStimulus(1, 8'd9, 0);
    checkOutput("bp_release_acc", 32'(acc_out), 0);
    checkOutput("bp_release_ready", 32'(in_ready), 1);
    applyStimulus(1, 8'd9, 0);
    checkOutput("bp_nine_acc", 32'(acc_out), 9);
    checkOutput("bp_nine_cnt", 32'(term_cnt), 1);
    applyStimulus(1, 8'd1, 1);
    checkOutput("bp_frame2_acc", 32'(acc_out), 10);
    checkOutput("bp_frame2_cnt", 32'(term_cnt), 2);
    applyStimulus(0, 8'd0, 0);

    // MAX_TERMS close after 16 unit terms
    for (int i = 0; i < 15; i++) applyStimulus(1, 8'd1, 0);
    checkOutput("max_15_ready", 32'(in_ready), 1);
    checkOutput("max_15_cnt", 32'(term_cnt), 15);
    applyStimulus(1, 8'd1, 0);
    checkOutput("max_valid", 32'(out_valid), 1);
    checkOutput("max_acc", 32'(acc_out), 16);
    checkOutput("max_cnt", 32'(term_cnt), 16);
    applyStimulus(0, 8'd0, 0);

    // Saturation: 5 x 225 = 1125 exceeds the 10-bit range
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'd225, 0);
    checkOutput("sat_900_acc10", 32'(acc_out10), 900);
    checkOutput("sat_900_ovf10", 32'(ovf10), 0);
    applyStimulus(1, 8'd225, 1);
    checkOutput("sat_acc10", 32'(acc_out10), 1023);
    checkOutput("sat_cnt10", 32'(term_cnt10), 5);
    checkOutput("sat_ovf10", 32'(ovf10), 1);
    checkOutput("sat_valid10", 32'(out_valid10), 1);
    checkOutput("nosat_acc16", 32'(acc_out), 1125);
    checkOutput("nosat_ovf16", 32'(ovf), 0);
    applyStimulus(0, 8'd0, 0);
    checkOutput("sat_consumed_ovf10", 32'(ovf10), 0);
    applyStimulus(1, 8'd3, 1);
    checkOutput("sat_next_acc10", 32'(acc_out10), 3);
    checkOutput("sat_next_ovf10", 32'(ovf10), 0);
    applyStimulus(0, 8'd0, 0);

    // Asynchronous reset in the middle of a frame
    applyStimulus(1, 8'd200, 0);
    applyStimulus(1, 8'd200, 0);
    checkOutput("rstmid_pre_acc", 32'(acc_out), 400);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_acc", 32'(acc_out), 0);
    checkOutput("rstmid_cnt", 32'(term_cnt), 0);
    #2 rst_n = 1'b1;
    applyStimulus(1, 8'd7, 1);
    checkOutput("rstmid_frame_acc", 32'(acc_out), 7);
    checkOutput("rstmid_frame_cnt", 32'(term_cnt), 1);
    checkOutput("rstmid_frame_valid", 32'(out_valid), 1);
    applyStimulus(0, 8'd0, 0);

    // clr collides with a presented term
    applyStimulus(1, 8'd10, 0);
    checkOutput("clr_pre_acc", 32'(acc_out), 10);
    clr = 1'b1;
    applyStimulus(1, 8'd20, 0);
    clr = 1'b0;
    checkOutput("clr_acc", 32'(acc_out), 0);
    checkOutput("clr_cnt", 32'(term_cnt), 0);
    checkOutput("clr_ready", 32'(in_ready), 1);
    applyStimulus(1, 8'd5, 1);
    checkOutput("clr_frame_acc", 32'(acc_out), 5);
    checkOutput("clr_frame_cnt", 32'(term_cnt), 1);

    // clr also aborts a held result
    out_ready = 1'b0;
    clr = 1'b1;
    applyStimulus(0, 8'd0, 0);
    clr = 1'b0;
    checkOutput("clr_hold_valid", 32'(out_valid), 0);
    checkOutput("clr_hold_acc", 32'(acc_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
